// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin front end for a shared external
// ripple adder. A granted request drives registered operands to the adder,
// waits SETTLE cycles for the carry chain to settle, captures the sum, and
// pulses done for one cycle with the owning requester id.
//
// SETTLE must lie in 1..15; the settle counter is 4 bits wide.
module adder_arbiter #(
  parameter int WIDTH  = 64,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             busy
);

  // Counter load value: the capture happens on the cycle the counter reads 0,
  // so loading SETTLE-1 gives exactly SETTLE cycles of settling time.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;       // tie-break priority: 0 -> req0 wins
  logic             owner_q, owner_d;   // requester that owns the operation
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic grant0;
  logic grant1;

  // Arbitration: a lone valid wins outright; ptr only breaks ties.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~ptr_q);
    grant1 = req1_valid & (~req0_valid |  ptr_q);
  end

  // State register with asynchronous clear; reset aborts any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      add_a_q <= '0;
      add_b_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and ready strobes; everything holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    sum_d      = sum_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          // Operands stay frozen in add_a/add_b until the next accept.
          add_a_d = grant1 ? req1_a : req0_a;
          add_b_d = grant1 ? req1_b : req0_b;
          owner_d = grant1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          // Carry-out is dropped: the sum is taken modulo 2^WIDTH.
          sum_d   = add_sum;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Hand priority to the other requester for round-robin fairness.
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come from registers only; add_sum never reaches them directly.
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign sum     = sum_q;
  assign done_id = owner_q;
  assign done    = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scoreboard bench for adder_arbiter (WIDTH=64,
// SETTLE=4). The stimulus process queues jobs per requester and pushes the
// hand-computed results in expected completion order; a monitor process pops
// and compares on every done pulse. The external adder is modelled so that
// its output is wrong until the operands have been stable for SETTLE cycles.
module tb_adder_arbiter;

  localparam int W  = 64;
  localparam int ST = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] s;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [W-1:0] add_a, add_b, add_sum, sum;
  logic         done, done_id, busy;

  job_t jobs0[$];
  job_t jobs1[$];
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int age      = 0;

  adder_arbiter #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .done       (done),
    .done_id    (done_id),
    .sum        (sum),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ripple adder model: garbage (the inverted sum) until settled.
  assign add_sum = (age >= ST - 1) ? (add_a + add_b) : ~(add_a + add_b);

  initial begin
    logic [W-1:0] pa = '0;
    logic [W-1:0] pb = '0;
    forever begin
      @(negedge clk);
      if (add_a !== pa || add_b !== pb) begin
        age = 0;
        pa  = add_a;
        pb  = add_b;
      end else if (age < 15) begin
        age++;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_job(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) jobs1.push_back('{a: a, b: b});
    else    jobs0.push_back('{a: a, b: b});
  endtask

  task automatic push_exp(input bit id, input logic [W-1:0] s);
    exp_q.push_back('{id: id, s: s});
  endtask

  // Feeds queued jobs until every expected result has been seen. Inputs move
  // just after posedge; accepts are judged at negedge. req1 is only offered
  // while start1 <= n < stop1 (n counts cycles within this run).
  task automatic run_jobs(input int start1, input int stop1);
    int n = 0;
    @(posedge clk); #1;
    while (exp_q.size() > 0 && n < 300) begin
      req0_valid = (jobs0.size() > 0);
      if (jobs0.size() > 0) begin
        req0_a = jobs0[0].a;
        req0_b = jobs0[0].b;
      end
      req1_valid = (jobs1.size() > 0) && (n >= start1) && (n < stop1);
      if (jobs1.size() > 0) begin
        req1_a = jobs1[0].a;
        req1_b = jobs1[0].b;
      end
      @(negedge clk);
      if (req0_valid && req0_ready) void'(jobs0.pop_front());
      if (req1_valid && req1_ready) void'(jobs1.pop_front());
      @(posedge clk); #1;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("run_drained", 64'(exp_q.size()), 64'd0);
    jobs0.delete();
    jobs1.delete();
  endtask

  // Monitor: scoreboard pops on done, latency, ready rules, reset values.
  initial begin
    int   ncyc = 0;
    int   lat;
    int   acc_cyc[$];
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_sum",   sum,       64'd0);
        chk("rst_add_a", add_a,     64'd0);
        chk("rst_add_b", add_b,     64'd0);
        acc_cyc.delete();
        prev_done = 1'b0;
      end else begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
          acc_cyc.push_back(ncyc);
        chk("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
        if (busy) chk("ready_busy", 64'({req0_ready, req1_ready}), 64'd0);
        if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
        if (done) begin
          $display("done id=%0d sum=%0h", done_id, sum);
          chk("done_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_id", 64'(done_id), 64'(e.id));
            chk("sum", sum, e.s);
          end
          lat = (acc_cyc.size() > 0) ? (ncyc - acc_cyc.pop_front()) : -1;
          chk("latency", 64'(lat), 64'(ST + 1));
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Tie right after reset: ptr=0 so req0 first, then req1.
    push_job(0, 64'd3, 64'd4);
    push_job(1, 64'd10, 64'd20);
    push_exp(0, 64'd7);
    push_exp(1, 64'd30);
    run_jobs(0, 1000);

    // Single request.
    push_job(0, 64'd5, 64'd7);
    push_exp(0, 64'd12);
    run_jobs(0, 1000);

    // Wrap: carry-out dropped.
    push_job(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    push_exp(1, 64'd0);
    run_jobs(0, 1000);

    // Fairness: both continuously valid, ids alternate 0,1,0,1,0,1.
    push_job(0, 64'd1, 64'd2);
    push_job(0, 64'd100, 64'd200);
    push_job(0, 64'd1000, 64'd24);
    push_job(1, 64'd7, 64'd8);
    push_job(1, 64'd50, 64'd50);
    push_job(1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000);
    push_exp(0, 64'd3);
    push_exp(1, 64'd15);
    push_exp(0, 64'd300);
    push_exp(1, 64'd100);
    push_exp(0, 64'd1024);
    push_exp(1, 64'd0);
    run_jobs(0, 1000);

    // Backpressure: req1 raised during req0 settle, served after IDLE.
    push_job(0, 64'd11, 64'd22);
    push_job(1, 64'd40, 64'd2);
    push_exp(0, 64'd33);
    push_exp(1, 64'd42);
    run_jobs(2, 1000);

    // req1 pulses valid only while busy, then withdraws: no side effect.
    push_job(0, 64'd9, 64'd9);
    push_job(1, 64'hDEAD, 64'd1);
    push_exp(0, 64'd18);
    run_jobs(2, 4);
    repeat (12) @(negedge clk);

    // Reset in SETTLE at counter==2: immediate clear, no done.
    @(posedge clk); #1;
    req0_a = 64'd77; req0_b = 64'd1; req0_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_busy_before", 64'(busy), 64'd1);
    chk("abort_sum_before", sum, 64'd18);
    reset_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_sum", sum, 64'd0);
    chk("async_add_a", add_a, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Fresh request after release completes normally.
    push_job(0, 64'd20, 64'd22);
    push_exp(0, 64'd42);
    run_jobs(0, 1000);

    repeat (10) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: operand and sum width in bits.
REQ-002 Parameter SETTLE, default 4, legal range 1..15: cycles allowed for the shared adder output to settle after operands are driven.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid, req1_valid  input  1 each  requester has an add pending.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  requester operands.
REQ-007 req0_ready, req1_ready  output  1 each  combinational accept strobe; valid&ready in a cycle = request accepted.
REQ-008 add_a, add_b  output  WIDTH each  registered operands driven to the external ripple adder.
REQ-009 add_sum  input  WIDTH  sum returned by the external ripple adder.
REQ-010 done  output  1  one-cycle pulse: result on sum is valid.
REQ-011 done_id  output  1  requester owning the current result (0 or 1).
REQ-012 sum  output  WIDTH  registered result, held until the next capture.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETTLE, DONE.
REQ-015 In IDLE with at least one valid, the arbiter SHALL grant exactly one requester: the lone valid one, or on a tie the one selected by priority pointer ptr.
REQ-016 readyN SHALL equal (state==IDLE) & grantN; ready is never high outside IDLE, and never high for both requesters.
REQ-017 On accept: latch a/b into add_a/add_b, latch owner id, load counter with SETTLE-1, go to SETTLE.
REQ-018 In SETTLE: counter decrements each cycle; when counter==0, capture add_sum into sum, go to DONE.
REQ-019 In DONE: done=1 and done_id=owner for exactly one cycle; ptr SHALL become ~owner; next state IDLE.
REQ-020 Latency: accept at edge T -> done high in the cycle after edge T+SETTLE+1; one operation per SETTLE+2 cycles maximum.
REQ-021 Sum SHALL be add_sum modulo 2^WIDTH; carry-out is not captured.
REQ-022 add_a/add_b SHALL remain stable from accept until the next accept.
REQ-023 Valid deasserted before accept SHALL leave no side effect; valid held during SETTLE/DONE is served no earlier than the next IDLE.
REQ-024 A requester held valid continuously SHALL be served within two operations (round-robin fairness).
REQ-025 ptr SHALL change only in DONE; a lone-valid grant does not consult ptr.
REQ-026 No combinational path from add_sum to any output.

Reset
REQ-027 reset_n low SHALL immediately force state=IDLE, ptr=0, counter=0, owner=0, add_a=add_b=0, sum=0, done=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL abort it: no done pulse, sum cleared.
REQ-029 After reset_n rises, the first accept may occur in the first IDLE cycle.

Verification (WIDTH=64, SETTLE=4)
REQ-030 Single request: req0 a=5, b=7 accepted at edge T -> done at T+5, done_id=0, sum=12, busy low next cycle.
REQ-031 Tie after reset: both valid (req0 3+4, req1 10+20) -> req0 first (sum=7, id 0), then req1 (sum=30, id 1); ready never both high.
REQ-032 Wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, done pulses normally.
REQ-033 Fairness: req0 and req1 continuously valid for 6 operations -> done_id alternates 0,1,0,1,0,1.
REQ-034 Reset in SETTLE: reset_n low at counter==2 -> outputs zero asynchronously, no done; new request after release completes normally.
REQ-035 Backpressure: req1 valid raised during req0 SETTLE -> req1_ready stays 0 until IDLE, then req1 accepted with correct sum.
